pwm_multi_gen: RTL and testbench
================================

Name: pwm_multi_gen

Overview:
Multi-channel PWM generator and the parametrised successor to the single-channel counter and pwm_gen pair. It has one shared WIDTH-bit timebase with a prescaler, up/down/centre-aligned counting, and NCH independent compare channels. Period, compare and function settings are double-buffered and committed only at a period boundary. It sits behind the register bank, which drives its configuration inputs, and its outputs go directly to pins.

Parameters:
NCH, 4, number of PWM channels (1..16)
WIDTH, 16, counter, period and compare width (4..32)
PSC_W, 8, prescaler width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  timebase enable
cnt_clr  in  1  synchronous counter clear (single-cycle pulse)
mode  in  2  00 up, 01 down, 10 up-down (centre), 11 treated as up
prescale  in  PSC_W  counter advances every prescale+1 clk cycles
period  in  WIDTH  staged period
cmp1  in  NCH*WIDTH  staged compare1, channel k at [k*WIDTH +: WIDTH]
cmp2  in  NCH*WIDTH  staged compare2, same packing
func  in  NCH*2  staged per-channel function: 00 left, 01 right, 10 window, 11 forced low
ch_en  in  NCH  per-channel output enable (not buffered)
update  in  1  request to commit staged values to shadow (pulse)
count  out  WIDTH  current counter value
dir  out  1  1 = counting down
period_evt  out  1  one-cycle pulse at the period boundary
upd_done  out  1  one-cycle pulse in the cycle the shadow registers load
pwm_out  out  NCH  PWM outputs

Behaviour:
- Reset values: count=0, dir=0 (dir=1 if mode=01 at reset release is NOT applied; dir updates on the first tick), prescaler=0, all shadows=0, upd_pend=0, period_evt=0, upd_done=0, pwm_out=0.
- Tick: the prescaler counts 0..prescale. A tick is asserted when the prescaler equals prescale and en=1, after which the prescaler returns to 0. The prescaler holds at 0 while en=0.
- Up mode: on each tick, count increments. If count==period_s, count goes to 0 and the tick is a boundary. dir=0.
- Down mode: on each tick, count decrements. If count==0, count goes to period_s and the tick is a boundary. dir=1.
- Up-down mode: count rises to period_s, dir sets, count falls to 0, dir clears. Only the 0-reached tick is a boundary; the peak is not. With period_s=0, count stays at 0 and every tick is a boundary.
- Boundary: period_evt pulses high for exactly 1 clk in the cycle after the boundary tick.
- Shadow commit: update sets upd_pend. On a boundary tick with upd_pend=1, period_s, cmp1_s, cmp2_s and func_s load from the inputs, upd_pend clears, and upd_done pulses in the same cycle as period_evt.
- Commit while disabled: if en=0 and update=1, the shadow registers load immediately on the next edge and upd_done pulses.
- Update coinciding with a boundary tick: the commit happens at that same boundary.
- cnt_clr: sets count=0, dir=0 and prescaler=0, and has priority over a tick. It does not touch shadow registers or upd_pend.
- Mode change: takes effect on the next tick. If count exceeds period_s, the next up tick wraps count to 0 (boundary).
- Channel functions, evaluated on registered count (c=count, a=cmp1_s, b=cmp2_s):
  - Left: high when c<a.
  - Right: high when c>=a.
  - Window: high when a<=c<b; if b<=a the output stays low.
  - 11: low.
- pwm_out[k] = function result AND ch_en[k], registered, so it lags count by 1 clk.
- Reset asserted mid-period: all state returns to reset values immediately (asynchronously).
- All comparisons are unsigned, WIDTH bits. There is no overflow beyond period_s.

Optional Feature:
Macro PWM_MULTI_DEADTIME_EN.
- With the macro defined:
  - Adds input dead_time (8 bits) and output pwm_out_n (NCH bits).
  - Each channel drives a complementary pair. On every edge of the raw channel signal, the newly active output stays low for dead_time clk cycles, using a per-channel 8-bit down-counter.
  - pwm_out and pwm_out_n are never both high.
  - If the raw signal toggles again before the counter expires, the counter restarts and both outputs stay low.
  - dead_time=0 gives pwm_out_n = ~pwm_out whenever ch_en=1; both outputs are 0 when ch_en=0.
  - Reset values are 0 for both outputs and the counters.
- Without the macro: these ports and counters are absent, and pwm_out behaves exactly as in Behaviour.

Test Plan:
- Prescaler and up-mode wrap: en=1, mode=00, prescale=0, period=9, commit with en=0 → count cycles 0..9; period_evt pulses every 10 clk; prescale=3 → every 40 clk.
- Left function, channel 0: cmp1=4 → pwm_out[0] high 4 of every 10 ticks, 1 clk after count. Window, channel 1: cmp1=2, cmp2=7 → high for count 2..6. Window with cmp1=7, cmp2=2 → always low.
- Double buffering: running with period=9, pulse update with cmp1=8 at count=3 → output unchanged until count wraps; upd_done coincides with period_evt; next period high for 8 ticks.
- Up-down mode: period=5 → count 0,1,2,3,4,5,4,3,2,1,0; dir is high while falling; period_evt only at 0, every 10 ticks.
- Priority: cnt_clr and a tick in the same cycle → count=0. Reset asserted mid-period → all outputs 0 without waiting for a clk edge.
- PWM_MULTI_DEADTIME_EN: dead_time=3, cmp1=4, period=9 → each output's rising edge is delayed 3 clk after the raw edge; pwm_out & pwm_out_n is never 1.

Source files
------------

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: multi-channel PWM generator.
// One shared WIDTH-bit timebase with a prescaler and up / down / centre-aligned
// counting drives NCH compare channels. Period, compare and function settings
// are double-buffered. The staged values move into the shadow registers only at
// a period boundary, or at once while the timebase is disabled.
// Optional feature macro: PWM_MULTI_DEADTIME_EN. It adds complementary outputs
// (pwm_out_n) with a programmable dead time (dead_time).
module pwm_multi_gen #(
  parameter int NCH   = 4,
  parameter int WIDTH = 16,
  parameter int PSC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 cnt_clr,
  input  logic [1:0]           mode,
  input  logic [PSC_W-1:0]     prescale,
  input  logic [WIDTH-1:0]     period,
  input  logic [NCH*WIDTH-1:0] cmp1,
  input  logic [NCH*WIDTH-1:0] cmp2,
  input  logic [NCH*2-1:0]     func,
  input  logic [NCH-1:0]       ch_en,
  input  logic                 update,
`ifdef PWM_MULTI_DEADTIME_EN
  input  logic [7:0]           dead_time,
  output logic [NCH-1:0]       pwm_out_n,
`endif
  output logic [WIDTH-1:0]     count,
  output logic                 dir,
  output logic                 period_evt,
  output logic                 upd_done,
  output logic [NCH-1:0]       pwm_out
);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_CENTRE = 2'b10,
    MODE_UP_ALT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    FN_LEFT   = 2'b00,
    FN_RIGHT  = 2'b01,
    FN_WINDOW = 2'b10,
    FN_LOW    = 2'b11
  } func_e;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);

  logic [PSC_W-1:0]     psc;
  logic                 tick;
  logic [WIDTH-1:0]     period_s;
  logic [NCH*WIDTH-1:0] cmp1_s;
  logic [NCH*WIDTH-1:0] cmp2_s;
  logic [NCH*2-1:0]     func_s;
  logic                 upd_pend;
  logic [WIDTH-1:0]     count_nx;
  logic                 dir_nx;
  logic                 boundary;
  logic                 commit;
  logic [NCH-1:0]       fres;

  assign tick = en && (psc == prescale);

  // A staged update is committed at a period boundary, or at once while the
  // timebase is stopped (no boundary would ever arrive).
  assign commit = (update && !en) || (boundary && (upd_pend || update));

  // Prescaler: counts 0..prescale while enabled and restarts after each tick.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, regardless of block order.
    if (rst) begin
      psc <= '0;
    end else if (cnt_clr || !en || tick) begin
      psc <= '0;
    end else begin
      psc <= psc + PSC_ONE;
    end
  end

  // Next counter value, direction and boundary flag for the selected mode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    count_nx = count;
    dir_nx   = dir;
    boundary = 1'b0;
    if (cnt_clr) begin
      count_nx = '0;
      dir_nx   = 1'b0;
    end else if (tick) begin
      case (mode_e'(mode))
        MODE_DOWN: begin
          dir_nx = 1'b1;
          if (count == '0) begin
            count_nx = period_s;
            boundary = 1'b1;
          end else begin
            count_nx = count - CNT_ONE;
          end
        end
        MODE_CENTRE: begin
          if (period_s == '0) begin
            count_nx = '0;
            dir_nx   = 1'b0;
            boundary = 1'b1;
          end else if (!dir && (count < period_s)) begin
            // Rising: dir flips as the peak is reached.
            count_nx = count + CNT_ONE;
            dir_nx   = ((count + CNT_ONE) == period_s);
          end else if (count <= CNT_ONE) begin
            // Falling into zero closes the period.
            count_nx = '0;
            dir_nx   = 1'b0;
            boundary = 1'b1;
          end else begin
            count_nx = count - CNT_ONE;
            dir_nx   = 1'b1;
          end
        end
        default: begin
          // Up counting; also catches a count left above a shrunken period.
          dir_nx = 1'b0;
          if (count >= period_s) begin
            count_nx = '0;
            boundary = 1'b1;
          end else begin
            count_nx = count + CNT_ONE;
          end
        end
      endcase
    end
  end

  // Timebase registers and the period-boundary pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      dir        <= 1'b0;
      period_evt <= 1'b0;
    end else begin
      count      <= count_nx;
      dir        <= dir_nx;
      period_evt <= boundary;
    end
  end

  // Shadow registers, pending-update flag and commit pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_s <= '0;
      cmp1_s   <= '0;
      cmp2_s   <= '0;
      func_s   <= '0;
      upd_pend <= 1'b0;
      upd_done <= 1'b0;
    end else if (commit) begin
      period_s <= period;
      cmp1_s   <= cmp1;
      cmp2_s   <= cmp2;
      func_s   <= func;
      upd_pend <= 1'b0;
      upd_done <= 1'b1;
    end else begin
      upd_done <= 1'b0;
      if (update) upd_pend <= 1'b1;
    end
  end

  // Raw channel function on the registered count; all compares are unsigned.
  function automatic logic ch_eval(input logic [1:0] fn, input logic [WIDTH-1:0] c,
                                   input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (func_e'(fn))
      FN_LEFT:   return c < a;
      FN_RIGHT:  return c >= a;
      FN_WINDOW: return (a < b) && (c >= a) && (c < b);
      default:   return 1'b0;
    endcase
  endfunction

  for (genvar k = 0; k < NCH; k++) begin : g_fn
    assign fres[k] = ch_eval(func_s[2*k +: 2], count,
                             cmp1_s[k*WIDTH +: WIDTH], cmp2_s[k*WIDTH +: WIDTH]);
  end

`ifdef PWM_MULTI_DEADTIME_EN
  for (genvar k = 0; k < NCH; k++) begin : g_dt
    logic       raw_q;
    logic [7:0] dt_cnt;
    logic [7:0] dt_nx;
    logic       p_q;
    logic       n_q;

    // Every raw edge restarts the dead-time count; otherwise it runs down to 0.
    always_comb begin
      if (fres[k] != raw_q) begin
        dt_nx = dead_time;
      end else if (dt_cnt != 8'd0) begin
        dt_nx = dt_cnt - 8'd1;
      end else begin
        dt_nx = 8'd0;
      end
    end

    // Complementary pair: neither side drives while the dead time runs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        raw_q  <= 1'b0;
        dt_cnt <= 8'd0;
        p_q    <= 1'b0;
        n_q    <= 1'b0;
      end else begin
        raw_q  <= fres[k];
        dt_cnt <= dt_nx;
        p_q    <= ch_en[k] &&  fres[k] && (dt_nx == 8'd0);
        n_q    <= ch_en[k] && !fres[k] && (dt_nx == 8'd0);
      end
    end

    assign pwm_out[k]   = p_q;
    assign pwm_out_n[k] = n_q;
  end
`else
  // Gated channel outputs, one clk behind count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= fres & ch_en;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen: directed steps and random settings,
// compared every cycle against a behavioural model of the timebase and channels.
module tb_pwm_multi_gen;
  localparam int NCH   = 4;
  localparam int WIDTH = 16;
  localparam int PSC_W = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 cnt_clr;
  logic [1:0]           mode;
  logic [PSC_W-1:0]     prescale;
  logic [WIDTH-1:0]     period;
  logic [NCH*WIDTH-1:0] cmp1;
  logic [NCH*WIDTH-1:0] cmp2;
  logic [NCH*2-1:0]     func;
  logic [NCH-1:0]       ch_en;
  logic                 update;
  logic [WIDTH-1:0]     count;
  logic                 dir;
  logic                 period_evt;
  logic                 upd_done;
  logic [NCH-1:0]       pwm_out;
`ifdef PWM_MULTI_DEADTIME_EN
  logic [7:0]           dead_time;
  logic [NCH-1:0]       pwm_out_n;
`endif

  always #5 clk = ~clk;

  pwm_multi_gen #(.NCH(NCH), .WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cnt_clr    (cnt_clr),
    .mode       (mode),
    .prescale   (prescale),
    .period     (period),
    .cmp1       (cmp1),
    .cmp2       (cmp2),
    .func       (func),
    .ch_en      (ch_en),
    .update     (update),
`ifdef PWM_MULTI_DEADTIME_EN
    .dead_time  (dead_time),
    .pwm_out_n  (pwm_out_n),
`endif
    .count      (count),
    .dir        (dir),
    .period_evt (period_evt),
    .upd_done   (upd_done),
    .pwm_out    (pwm_out)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int             m_cnt, m_ph, m_ncyc, m_p;
  logic           m_dir, m_evt, m_done, m_pend;
  logic [NCH-1:0] m_pwm, m_raw, m_en_s;
  int             m_c1[NCH], m_c2[NCH], m_fn[NCH];
  logic [NCH-1:0] hist[4];
  int             hist_n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic spec_out(int fn, int c, int a, int b);
    case (fn)
      0:       return c < a;
      1:       return c >= a;
      2:       return (b > a) && (c >= a) && (c < b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_ph = 0; m_ncyc = 0; m_p = 0;
    m_dir = 0; m_evt = 0; m_done = 0; m_pend = 0;
    m_pwm = '0; m_raw = '0; m_en_s = '0; hist_n = 0;
    for (int k = 0; k < NCH; k++) begin
      m_c1[k] = 0; m_c2[k] = 0; m_fn[k] = 0;
    end
    for (int i = 0; i < 4; i++) hist[i] = '0;
  endtask

  // One clock edge of the model, using the inputs as they are at the edge.
  task automatic model_step();
    logic [NCH-1:0] f;
    bit tk, bnd, commit;
    int ps;
    for (int k = 0; k < NCH; k++) f[k] = spec_out(m_fn[k], m_cnt, m_c1[k], m_c2[k]);
    ps  = int'(prescale);
    tk  = en && ((m_ncyc % (ps + 1)) == ps);
    bnd = 0;
    if (cnt_clr) begin
      m_cnt = 0; m_ph = 0; m_dir = 0;
    end else if (tk) begin
      if (mode == 2'b10) begin
        // Triangle: phase walks 0..2P-1, count is the distance from zero.
        if (m_p == 0) begin
          bnd = 1; m_ph = 0; m_cnt = 0; m_dir = 0;
        end else begin
          m_ph  = (m_ph + 1) % (2 * m_p);
          m_cnt = (m_ph <= m_p) ? m_ph : 2 * m_p - m_ph;
          m_dir = (m_ph >= m_p);
          bnd   = (m_ph == 0);
        end
      end else if (mode == 2'b01) begin
        m_dir = 1;
        bnd   = (m_cnt == 0);
        m_cnt = bnd ? m_p : m_cnt - 1;
      end else begin
        m_dir = 0;
        bnd   = (m_cnt >= m_p);
        m_cnt = bnd ? 0 : m_cnt + 1;
      end
    end
    if (cnt_clr || !en) m_ncyc = 0;
    else                m_ncyc++;
    commit = (update && !en) || (bnd && (m_pend || update));
    if (commit) begin
      m_p = int'(period);
      for (int k = 0; k < NCH; k++) begin
        m_c1[k] = int'(cmp1[k*WIDTH +: WIDTH]);
        m_c2[k] = int'(cmp2[k*WIDTH +: WIDTH]);
        m_fn[k] = int'(func[2*k +: 2]);
      end
      m_pend = 0;
    end else if (update) begin
      m_pend = 1;
    end
    m_evt  = bnd;
    m_done = commit;
    m_raw  = f;
    m_pwm  = f & ch_en;
    m_en_s = ch_en;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = f;
    hist_n++;
  endtask

  task automatic check_all();
    check("count", 64'(count), 64'(m_cnt));
    check("dir", 64'(dir), 64'(m_dir));
    check("period_evt", 64'(period_evt), 64'(m_evt));
    check("upd_done", 64'(upd_done), 64'(m_done));
`ifdef PWM_MULTI_DEADTIME_EN
    check("pwm_overlap", 64'(pwm_out & pwm_out_n), 64'(0));
    if (dead_time == 8'd0) begin
      check("pwm_out", 64'(pwm_out), 64'(m_pwm));
      check("pwm_out_n", 64'(pwm_out_n), 64'(m_en_s & ~m_raw));
    end else if (hist_n >= 4) begin
      // With dead time 3 a side drives only after 4 stable raw samples.
      check("dt_pwm_out", 64'(pwm_out),
            64'(m_en_s & hist[0] & hist[1] & hist[2] & hist[3]));
      check("dt_pwm_out_n", 64'(pwm_out_n),
            64'(m_en_s & ~hist[0] & ~hist[1] & ~hist[2] & ~hist[3]));
    end
`else
    check("pwm_out", 64'(pwm_out), 64'(m_pwm));
`endif
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic set_ch(input int k, input int fn, input int a, input int b);
    func[2*k +: 2]         = 2'(fn);
    cmp1[k*WIDTH +: WIDTH] = WIDTH'(a);
    cmp2[k*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic pulse_update();
    update = 1'b1;
    step(1);
    update = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cnt_clr = 1'b0; mode = 2'b00; prescale = '0;
    period = '0; cmp1 = '0; cmp2 = '0; func = '0; ch_en = '0; update = 1'b0;
`ifdef PWM_MULTI_DEADTIME_EN
    dead_time = 8'd0;
`endif
    model_reset();

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Commit while disabled: period 9, left / window / inverted window / right.
    period = WIDTH'(9);
    ch_en  = '1;
    set_ch(0, 0, 4, 0);
    set_ch(1, 2, 2, 7);
    set_ch(2, 2, 7, 2);
    set_ch(3, 1, $urandom_range(0, 10), 0);
    pulse_update();
    step(1);

    // Up mode, prescale 0: period_evt every 10 clk.
    en = 1'b1;
    step(25);

    // Prescale 3: period_evt every 40 clk.
    en = 1'b0; prescale = PSC_W'(3);
    step(1);
    en = 1'b1;
    step(90);

    // Double buffering: new compare staged at count 3 waits for the wrap.
    en = 1'b0; prescale = '0;
    step(1);
    en = 1'b1;
    for (int i = 0; i < 40 && m_cnt != 3; i++) step(1);
    set_ch(0, 0, 8, 0);
    set_ch(3, $urandom_range(0, 3), $urandom_range(0, 10), $urandom_range(0, 10));
    pulse_update();
    step(25);

    // Period shrunk below count while disabled: next up tick wraps.
    for (int i = 0; i < 40 && m_cnt < 7; i++) step(1);
    en = 1'b0; period = WIDTH'(4);
    pulse_update();
    en = 1'b1;
    step(12);

    // Up-down, period 5.
    en = 1'b0; cnt_clr = 1'b1; mode = 2'b10; period = WIDTH'(5);
    pulse_update();
    cnt_clr = 1'b0; en = 1'b1;
    step(30);

    // Up-down with period 0: every tick is a boundary.
    en = 1'b0; cnt_clr = 1'b1; period = '0;
    pulse_update();
    cnt_clr = 1'b0; en = 1'b1;
    step(6);

    // Down mode, period 6.
    en = 1'b0; cnt_clr = 1'b1; mode = 2'b01; period = WIDTH'(6);
    pulse_update();
    cnt_clr = 1'b0; en = 1'b1;
    step(25);

    // cnt_clr in the same cycle as a tick wins.
    cnt_clr = 1'b1;
    step(1);
    check("clr_prio", 64'(count), 64'(0));
    cnt_clr = 1'b0;
    step(5);

    // Random configurations with a mid-run staged update.
    for (int it = 0; it < 8; it++) begin
      en = 1'b0; cnt_clr = 1'b1;
      mode     = 2'($urandom_range(0, 3));
      period   = WIDTH'($urandom_range(0, 12));
      prescale = PSC_W'($urandom_range(0, 2));
      ch_en    = NCH'($urandom);
      for (int k = 0; k < NCH; k++)
        set_ch(k, $urandom_range(0, 3), $urandom_range(0, 13), $urandom_range(0, 13));
      pulse_update();
      cnt_clr = 1'b0; en = 1'b1;
      step($urandom_range(10, 30));
      period = WIDTH'($urandom_range(0, 12));
      for (int k = 0; k < NCH; k++)
        set_ch(k, $urandom_range(0, 3), $urandom_range(0, 13), $urandom_range(0, 13));
      pulse_update();
      step($urandom_range(20, 40));
    end

    // Asynchronous reset in mid-period.
    en = 1'b0; cnt_clr = 1'b1; mode = 2'b00; prescale = '0; period = WIDTH'(9);
    ch_en = '1;
    set_ch(0, 1, 0, 0);
    pulse_update();
    cnt_clr = 1'b0; en = 1'b1;
    step(6);
    #2 rst = 1'b1;
    #1;
    check("async_count", 64'(count), 64'(0));
    check("async_dir", 64'(dir), 64'(0));
    check("async_pwm", 64'(pwm_out), 64'(0));
    check("async_evt", 64'(period_evt), 64'(0));
    check("async_done", 64'(upd_done), 64'(0));
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    step(3);

`ifdef PWM_MULTI_DEADTIME_EN
    // Dead time 3 on left-aligned channels, compare 4, period 9.
    en = 1'b0; cnt_clr = 1'b1; mode = 2'b00; period = WIDTH'(9); ch_en = '1;
    for (int k = 0; k < NCH; k++) set_ch(k, 0, 4, 0);
    pulse_update();
    cnt_clr = 1'b0; en = 1'b1;
    dead_time = 8'd3;
    hist_n = 0;
    step(45);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
